uart_rx_errchk: RTL and testbench

//  Parametrised UART receiver with error detection. It samples the serial

---
 rtl/uart_rx_errchk.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx_errchk.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_errchk.sv
// Parametrised UART receiver: oversampled 3-sample majority voting, parity,
// framing, break and overrun detection, FWFT receive FIFO with valid/ready.
module uart_rx_errchk #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        rxd,
  output logic [DATA_WIDTH-1:0]       rx_data,
  output logic                        rx_parity_err,
  output logic                        rx_frame_err,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        overrun,
  output logic                        break_det,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int unsigned SAMP_RATE = BAUD_RATE * OVERSAMPLE;
  localparam int unsigned DIV       = (CLK_FREQ + SAMP_RATE / 2) / SAMP_RATE;
  localparam int unsigned DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PH_W      = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W     = $clog2(DATA_WIDTH);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned ENT_W     = DATA_WIDTH + 2;

  localparam logic [PH_W-1:0] PH_S0   = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0] PH_S1   = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0] PH_S2   = PH_W'(OVERSAMPLE / 2 + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
  } state_t;

  logic                  sync1_q, sync2_q, rx_s, rx_prev_q;
  logic [1:0]            rst_sh_q;
  logic                  armed_q, armed_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  tick, decide, maj;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [1:0]            smp_q, smp_d;
  state_t                state_q, state_d;
  logic [BIT_W-1:0]      bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  perr_q, perr_d, ferr_q, ferr_d, par_bit_q, par_bit_d;
  logic                  stopcnt_q, stopcnt_d, ferr_n;
  logic                  push, push_ferr, brk_d;
  logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]      head;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  pop, full, do_push, ovr_d;
  logic                  overrun_q, break_det_q;

  assign rx_s   = sync2_q;
  assign tick   = (div_q == DIV_W'(DIV - 1));
  assign decide = tick && (phase_q == PH_S2);
  assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

  always_comb begin
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    phase_d   = phase_q;
    smp_d     = smp_q;
    state_d   = state_q;
    armed_d   = armed_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    par_bit_d = par_bit_q;
    stopcnt_d = stopcnt_q;
    ferr_n    = ferr_q | ~maj;
    push      = 1'b0;
    push_ferr = 1'b0;
    brk_d     = 1'b0;
    if (tick) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
      if (phase_q == PH_S0) smp_d[0] = rx_s;
      if (phase_q == PH_S1) smp_d[1] = rx_s;
    end
    unique case (state_q)
      S_IDLE: begin
        // Synchroniser holds 1 for two cycles after reset; judge the line only once it is real.
        if (rst_sh_q[1]) begin
          if (!armed_q) begin
            if (rx_s) begin
              armed_d = 1'b1;
            end else begin
              state_d = S_BRKWAIT;
              phase_d = '0;
            end
          end else if (rx_prev_q && !rx_s) begin
            state_d = S_START;
            phase_d = '0;
          end
        end
      end
      S_START: if (decide) begin
        if (maj) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_DATA;
          bitcnt_d = '0;
          perr_d   = 1'b0;
          ferr_d   = 1'b0;
        end
      end
      S_DATA: if (decide) begin
        shreg_d = {maj, shreg_q[DATA_WIDTH-1:1]};
        if (bitcnt_q == BIT_W'(DATA_WIDTH - 1)) begin
          state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          stopcnt_d = 1'b0;
        end else begin
          bitcnt_d = bitcnt_q + BIT_W'(1);
        end
      end
      S_PARITY: if (decide) begin
        par_bit_d = maj;
        perr_d    = ((^shreg_q) ^ maj) != (PARITY == 2);
        state_d   = S_STOP;
        stopcnt_d = 1'b0;
      end
      S_STOP: if (decide) begin
        if (!stopcnt_q && !maj && (shreg_q == '0) && ((PARITY == 0) || !par_bit_q)) begin
          push      = 1'b1;
          push_ferr = 1'b1;
          brk_d     = 1'b1;
          state_d   = S_BRKWAIT;
          phase_d   = '0;
        end else if (stopcnt_q == 1'(STOP_BITS - 1)) begin
          push      = 1'b1;
          push_ferr = ferr_n;
          state_d   = S_IDLE;
        end else begin
          stopcnt_d = 1'b1;
          ferr_d    = ferr_n;
        end
      end
      S_BRKWAIT: begin
        // Phase counter doubles as the "line high for one full bit" timer.
        if (!rx_s) begin
          phase_d = '0;
        end else if (tick && (phase_q == PH_LAST)) begin
          state_d = S_IDLE;
          armed_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_valid = (count_q != '0);
  assign pop      = rx_valid && rx_ready;
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign do_push  = push && (!full || pop);
  assign ovr_d    = push && full && !pop;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !pop) count_d = count_q + CNT_W'(1);
    if (!do_push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rst_sh_q    <= '0;
      armed_q     <= 1'b0;
      div_q       <= '0;
      phase_q     <= '0;
      smp_q       <= '1;
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      par_bit_q   <= 1'b0;
      stopcnt_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      break_det_q <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync1_q     <= rxd;
      sync2_q     <= sync1_q;
      rx_prev_q   <= sync2_q;
      rst_sh_q    <= {rst_sh_q[0], 1'b1};
      armed_q     <= armed_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      smp_q       <= smp_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      par_bit_q   <= par_bit_d;
      stopcnt_q   <= stopcnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= ovr_d;
      break_det_q <= brk_d;
      if (do_push) mem_q[wr_ptr_q] <= {shreg_q, perr_q, push_ferr};
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign rx_data       = head[ENT_W-1:2];
  assign rx_parity_err = head[1];
  assign rx_frame_err  = head[0];
  assign overrun       = overrun_q;
  assign break_det     = break_det_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_uart_rx_errchk.sv
// Directed bench for uart_rx_errchk (8E1, 4-deep FIFO) with a scoreboard of expected frames.
module tb_uart_rx_errchk;
  localparam int unsigned CLK_FREQ = 3_686_400;
  localparam int unsigned BIT_CLKS = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_parity_err, rx_frame_err, rx_valid, overrun, break_det;
  logic [2:0] fifo_count;

  uart_rx_errchk #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(115_200), .DATA_WIDTH(8), .PARITY(1),
    .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rxd(rxd), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun),
    .break_det(break_det), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail = 0;
  int         valid_cyc = 0;
  int         brk_cnt = 0;
  int         ovr_cnt = 0;
  logic [9:0] sb_q[$];
  logic [9:0] mon_exp;
  logic [7:0] hold_data = '0;
  logic       hold_vld = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted head, counts pulses.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid) valid_cyc++;
      if (break_det) brk_cnt++;
      if (overrun) ovr_cnt++;
      if (hold_vld && rx_valid) chk("head_stable", rx_data, hold_data);
      hold_vld  = rx_valid && !rx_ready;
      hold_data = rx_data;
      if (rx_valid && rx_ready) begin
        chk("pop_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          mon_exp = sb_q.pop_front();
          chk("rx_data", rx_data, mon_exp[9:2]);
          chk("rx_parity_err", rx_parity_err, mon_exp[1]);
          chk("rx_frame_err", rx_frame_err, mon_exp[0]);
        end
      end
    end else begin
      hold_vld = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    rxd = 1'b0;
    cyc(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      cyc(BIT_CLKS);
    end
    rxd = par;
    cyc(BIT_CLKS);
    rxd = stop;
    cyc(BIT_CLKS);
    rxd = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d);
    sb_q.push_back({d, 1'b0, 1'b0});
    send_frame(d, ^d, 1'b1);
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 4000 && fifo_count != 0; i++) cyc(1);
    chk(tag, fifo_count, 0);
    chk({tag, "_sb"}, sb_q.size(), 0);
  endtask

  initial begin
    cyc(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_perr", rx_parity_err, 0);
    chk("rst_ferr", rx_frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_break", break_det, 0);
    chk("rst_count", fifo_count, 0);
    reset_n = 1'b1;
    cyc(3 * BIT_CLKS);

    valid_cyc = 0;
    send_good(8'h45);
    cyc(BIT_CLKS);
    chk("t1_valid_cycles", valid_cyc, 1);
    wait_empty("t1_empty");

    sb_q.push_back({8'h4E, 1'b1, 1'b0});
    send_frame(8'h4E, ~(^8'h4E), 1'b1);
    cyc(BIT_CLKS);
    send_good(8'h4E);
    cyc(BIT_CLKS);
    wait_empty("t2_empty");

    brk_cnt = 0;
    sb_q.push_back({8'h52, 1'b0, 1'b1});
    send_frame(8'h52, ^8'h52, 1'b0);
    cyc(2 * BIT_CLKS);
    chk("t3_no_break", brk_cnt, 0);
    send_good(8'h49);
    cyc(BIT_CLKS);
    wait_empty("t3_empty");

    valid_cyc = 0;
    rxd = 1'b0;
    cyc(6);
    rxd = 1'b1;
    cyc(3 * BIT_CLKS);
    chk("t4_count", fifo_count, 0);
    chk("t4_no_valid", valid_cyc, 0);
    send_good(8'h33);
    cyc(BIT_CLKS);
    wait_empty("t4_empty");

    rx_ready = 1'b0;
    ovr_cnt  = 0;
    send_good(8'h45);
    send_good(8'h4E);
    send_good(8'h52);
    send_good(8'h49);
    send_frame(8'h51, ^8'h51, 1'b1);
    cyc(BIT_CLKS);
    chk("t5_count", fifo_count, 4);
    chk("t5_overrun", ovr_cnt, 1);
    chk("t5_head", rx_data, 8'h45);
    chk("t5_valid", rx_valid, 1);
    rx_ready = 1'b1;
    wait_empty("t5_drain");

    brk_cnt = 0;
    ovr_cnt = 0;
    sb_q.push_back({8'h00, 1'b0, 1'b1});
    rxd = 1'b0;
    cyc(33 * BIT_CLKS);
    rxd = 1'b1;
    cyc(3 * BIT_CLKS);
    chk("t6_break_pulses", brk_cnt, 1);
    chk("t6_no_overrun", ovr_cnt, 0);
    wait_empty("t6_break_empty");
    send_good(8'h55);
    cyc(BIT_CLKS);
    wait_empty("t6_after_break");

    brk_cnt = 0;
    rxd = 1'b0;
    cyc(5 * BIT_CLKS);
    reset_n = 1'b0;
    cyc(4);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_valid", rx_valid, 0);
    reset_n = 1'b1;
    cyc(11 * BIT_CLKS);
    rxd = 1'b1;
    cyc(3 * BIT_CLKS);
    chk("t6_rst_no_break", brk_cnt, 0);
    chk("t6_rst_empty", fifo_count, 0);
    send_good(8'h5A);
    cyc(BIT_CLKS);
    wait_empty("t6_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
